// File: rtl/multicycle_control.sv
// -----------------------------------------------------------------------------
// multicycle_control
// Multicycle RV32I control unit. Sequences FETCH/DECODE/EXEC/MEM/WB around a
// ready-handshake memory port and drives the multicycle datapath with the
// same control vector as the single-cycle main decoder, plus PCWrite, IRWrite
// and mem_req.
//
// Optional feature macro: ILLEGAL_TRAP_EN
//   defined   -> opcodes outside the decode table trap from DECODE, illegal=1
//   undefined -> unknown opcodes follow the R-type path, illegal tied 0
//
// Parameters
//   ALUOP_W      ALUOp width (>=3), upper bits zero-extended
//   MEM_TIMEOUT  wait cycles on mem_ready before bus error (0 = no timeout)
//
// Ports
//   CLK, RST_n        clock (rising edge), async active-low reset
//   en                0 freezes state/counter and forces all strobes low
//   opcode            inst[6:0] from memory read data, sampled on FETCH+ready
//   mem_ready         memory completes the current request this cycle
//   mem_req           memory request (FETCH, MEM)
//   IRWrite, PCWrite  instruction-register / PC update strobes
//   Branch, MemRead, MemWrite, RegWrite    strobes
//   MemtoReg, ALUSrc, Jal, Jalr, ALUOp, AuipcLui  registered decode fields
//   state_o           FETCH=0 DECODE=1 EXEC=2 MEM=3 WB=4 TRAP=7
//   bus_err, illegal  sticky error flags
// -----------------------------------------------------------------------------
//  state  | meaning
//  FETCH  | request instruction, capture opcode on mem_ready
//  DECODE | register decode fields from captured opcode
//  EXEC   | branch resolves here; loads/stores go to MEM, rest to WB
//  MEM    | data access, wait for mem_ready
//  WB     | register write-back and PC update
//  TRAP   | bus timeout or illegal opcode; left only through reset
// -----------------------------------------------------------------------------
module multicycle_control #(
    parameter int ALUOP_W     = 3,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic               CLK,
    input  logic               RST_n,
    input  logic               en,
    input  logic [6:0]         opcode,
    input  logic               mem_ready,
    output logic               mem_req,
    output logic               IRWrite,
    output logic               PCWrite,
    output logic               Branch,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               RegWrite,
    output logic               MemtoReg,
    output logic               ALUSrc,
    output logic               Jal,
    output logic               Jalr,
    output logic [ALUOP_W-1:0] ALUOp,
    output logic [1:0]         AuipcLui,
    output logic [2:0]         state_o,
    output logic               bus_err,
    output logic               illegal
);

    localparam int CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_B     = 7'b1100011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LW    = 7'b0000011;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        TRAP   = 3'd7
    } state_t;

    state_t     state, state_nxt;
    logic [6:0] opcode_q;
    logic [CNT_W-1:0] wait_cnt;

    logic       ir_load;
    logic       cnt_inc;
    logic       set_bus_err;
    logic       timeout_hit;

    logic [2:0] dec_aluop;
    logic [1:0] dec_auipclui;
    logic       dec_alusrc, dec_memtoreg, dec_jal, dec_jalr;
    logic       is_b, is_lw, is_sw;

    assign state_o = state;
    assign is_b    = (opcode_q == OP_B);
    assign is_lw   = (opcode_q == OP_LW);
    assign is_sw   = (opcode_q == OP_SW);

    // The limit cycle only traps when mem_ready is low; a late ready still wins.
    assign timeout_hit = (MEM_TIMEOUT > 0) && (wait_cnt == CNT_W'(MEM_TIMEOUT));

    // Decode table; R-type and unknown opcodes share the default row.
    always_comb begin
        dec_aluop    = 3'b000;
        dec_alusrc   = 1'b0;
        dec_memtoreg = 1'b0;
        dec_auipclui = 2'b10;
        dec_jal      = 1'b0;
        dec_jalr     = 1'b0;
        case (opcode_q)
            OP_I:     begin dec_aluop = 3'b001; dec_alusrc = 1'b1; end
            OP_B:     begin dec_aluop = 3'b010; end
            OP_SW:    begin dec_aluop = 3'b011; dec_alusrc = 1'b1; end
            OP_AUIPC: begin dec_aluop = 3'b100; dec_alusrc = 1'b1; dec_auipclui = 2'b00; end
            OP_LUI:   begin dec_aluop = 3'b100; dec_alusrc = 1'b1; dec_auipclui = 2'b01; end
            OP_JAL:   begin dec_aluop = 3'b101; dec_alusrc = 1'b1; dec_jal = 1'b1; end
            OP_JALR:  begin dec_aluop = 3'b101; dec_alusrc = 1'b1; dec_jal = 1'b1; dec_jalr = 1'b1; end
            OP_LW:    begin dec_aluop = 3'b110; dec_alusrc = 1'b1; dec_memtoreg = 1'b1; end
            default:  ;
        endcase
    end

`ifdef ILLEGAL_TRAP_EN
    logic is_legal;
    logic set_illegal;

    assign is_legal = opcode_q inside {OP_R, OP_I, OP_B, OP_SW, OP_AUIPC,
                                       OP_LUI, OP_JAL, OP_JALR, OP_LW};

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            illegal <= 1'b0;
        end else if (en && set_illegal) begin
            illegal <= 1'b1;
        end
    end
`else
    assign illegal = 1'b0;
`endif

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state <= FETCH;
        end else if (en) begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        mem_req     = 1'b0;
        IRWrite     = 1'b0;
        PCWrite     = 1'b0;
        Branch      = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        RegWrite    = 1'b0;
        ir_load     = 1'b0;
        cnt_inc     = 1'b0;
        set_bus_err = 1'b0;
`ifdef ILLEGAL_TRAP_EN
        set_illegal = 1'b0;
`endif
        if (en) begin
            case (state)
                FETCH: begin
                    mem_req = 1'b1;
                    MemRead = 1'b1;
                    if (mem_ready) begin
                        IRWrite   = 1'b1;
                        ir_load   = 1'b1;
                        state_nxt = DECODE;
                    end else if (timeout_hit) begin
                        set_bus_err = 1'b1;
                        state_nxt   = TRAP;
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
                DECODE: begin
`ifdef ILLEGAL_TRAP_EN
                    if (!is_legal) begin
                        set_illegal = 1'b1;
                        state_nxt   = TRAP;
                    end else begin
                        state_nxt = EXEC;
                    end
`else
                    state_nxt = EXEC;
`endif
                end
                EXEC: begin
                    if (is_b) begin
                        Branch    = 1'b1;
                        PCWrite   = 1'b1;
                        state_nxt = FETCH;
                    end else if (is_lw || is_sw) begin
                        state_nxt = MEM;
                    end else begin
                        state_nxt = WB;
                    end
                end
                MEM: begin
                    mem_req  = 1'b1;
                    MemRead  = is_lw;
                    MemWrite = is_sw;
                    if (mem_ready) begin
                        if (is_sw) begin
                            PCWrite   = 1'b1;
                            state_nxt = FETCH;
                        end else begin
                            state_nxt = WB;
                        end
                    end else if (timeout_hit) begin
                        set_bus_err = 1'b1;
                        state_nxt   = TRAP;
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
                WB: begin
                    RegWrite  = 1'b1;
                    PCWrite   = 1'b1;
                    state_nxt = FETCH;
                end
                TRAP:    ;
                default: state_nxt = FETCH;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            opcode_q <= '0;
            wait_cnt <= '0;
            ALUOp    <= '0;
            ALUSrc   <= 1'b0;
            MemtoReg <= 1'b0;
            AuipcLui <= 2'b10;
            Jal      <= 1'b0;
            Jalr     <= 1'b0;
            bus_err  <= 1'b0;
        end else if (en) begin
            if (state_nxt != state) begin
                wait_cnt <= '0;
            end else if (cnt_inc) begin
                wait_cnt <= wait_cnt + CNT_W'(1);
            end
            if (ir_load) begin
                opcode_q <= opcode;
            end
            if (state == DECODE) begin
                ALUOp    <= ALUOP_W'(dec_aluop);
                ALUSrc   <= dec_alusrc;
                MemtoReg <= dec_memtoreg;
                AuipcLui <= dec_auipclui;
                Jal      <= dec_jal;
                Jalr     <= dec_jalr;
            end
            if (set_bus_err) begin
                bus_err <= 1'b1;
            end
        end
    end

endmodule
